// File: rtl/pdp_preproc_pkg.sv
// pdp_preproc_pkg
//   Shared widths, info-tag bit positions and the payload layout used by the
//   PDP pre-processing stage (pdp_core_preproc) and its on-fly position
//   counter (pdp_onfly_pos_cnt). Payload is {info, data}, info in the MSBs.
package pdp_preproc_pkg;

  localparam int DATA_W = 8;
  localparam int INFO_W = 12;
  localparam int ATOM_C = 8;
  localparam int PD_W   = DATA_W + INFO_W;
  localparam int CPOS_W = $clog2(ATOM_C);
  localparam int CUBE_W = 13;
  // Surface (atom-group) counter only needs the channel bits above the atom.
  localparam int SURF_W = CUBE_W - CPOS_W;

  localparam logic [CPOS_W-1:0] CPOS_LAST = CPOS_W'(ATOM_C - 1);

  localparam int INFO_CPOS_LSB  = 0;
  localparam int INFO_CPOS_MSB  = CPOS_W - 1;
  localparam int INFO_ATOM_END  = 3;
  localparam int INFO_LINE_END  = 4;
  localparam int INFO_SURF_END  = 5;
  localparam int INFO_SPLIT_END = 7;
  localparam int INFO_CUBE_END  = 11;

  typedef struct packed {
    logic [INFO_W-1:0] info;
    logic [DATA_W-1:0] data;
  } pdp_pd_t;

  // Assemble the info tag; reserved bits are zero. On-fly is a single split,
  // so split_end mirrors cube_end.
  function automatic logic [INFO_W-1:0] pdp_make_info(
    input logic [CPOS_W-1:0] cpos,
    input logic              atom_end,
    input logic              line_end,
    input logic              surf_end,
    input logic              cube_end
  );
    logic [INFO_W-1:0] info;
    info = {INFO_W{1'b0}};
    info[INFO_CPOS_MSB:INFO_CPOS_LSB] = cpos;
    info[INFO_ATOM_END]  = atom_end;
    info[INFO_LINE_END]  = line_end;
    info[INFO_SURF_END]  = surf_end;
    info[INFO_SPLIT_END] = cube_end;
    info[INFO_CUBE_END]  = cube_end;
    return info;
  endfunction

endpackage

// File: rtl/pdp_onfly_pos_cnt.sv
// pdp_onfly_pos_cnt
//   Nested position counters for on-fly (SDP) elements: channel-in-atom
//   (innermost), width, height, surface. Produces the info tag for the element
//   currently offered and its cube_end flag; all flags describe the current
//   position, i.e. before the step is applied.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   step_i     : an on-fly element is accepted this cycle
//   clear_i    : return all counters to 0 (wins over step_i)
//   width_i / height_i : cube width-1 / height-1
//   surf_max_i : number of atom surfaces - 1 (channel-1 >> log2(ATOM_C))
//   info_o     : info tag of the current element
//   cube_end_o : current element is the last of the cube
module pdp_onfly_pos_cnt
  import pdp_preproc_pkg::*;
(
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [CUBE_W-1:0] width_i,
  input  logic [CUBE_W-1:0] height_i,
  input  logic [SURF_W-1:0] surf_max_i,
  output logic [INFO_W-1:0] info_o,
  output logic              cube_end_o
);

  logic [CPOS_W-1:0] c_cnt_q, c_cnt_d;
  logic [CUBE_W-1:0] w_cnt_q, w_cnt_d;
  logic [CUBE_W-1:0] h_cnt_q, h_cnt_d;
  logic [SURF_W-1:0] s_cnt_q, s_cnt_d;

  logic atom_end_s, line_end_s, surf_end_s, cube_end_s;

  assign atom_end_s = (c_cnt_q == CPOS_LAST);
  assign line_end_s = atom_end_s & (w_cnt_q == width_i);
  assign surf_end_s = line_end_s & (h_cnt_q == height_i);
  assign cube_end_s = surf_end_s & (s_cnt_q == surf_max_i);

  // Next-state for the nested counters: each outer counter moves only when
  // every inner counter wraps in the same step.
  always_comb begin
    c_cnt_d = c_cnt_q;
    w_cnt_d = w_cnt_q;
    h_cnt_d = h_cnt_q;
    s_cnt_d = s_cnt_q;
    if (clear_i) begin
      c_cnt_d = {CPOS_W{1'b0}};
      w_cnt_d = {CUBE_W{1'b0}};
      h_cnt_d = {CUBE_W{1'b0}};
      s_cnt_d = {SURF_W{1'b0}};
    end else if (step_i) begin
      c_cnt_d = atom_end_s ? {CPOS_W{1'b0}} : (c_cnt_q + CPOS_W'(1'b1));
      if (atom_end_s) begin
        w_cnt_d = line_end_s ? {CUBE_W{1'b0}} : (w_cnt_q + 13'd1);
      end else begin
        w_cnt_d = w_cnt_q;
      end
      if (line_end_s) begin
        h_cnt_d = surf_end_s ? {CUBE_W{1'b0}} : (h_cnt_q + 13'd1);
      end else begin
        h_cnt_d = h_cnt_q;
      end
      if (surf_end_s) begin
        s_cnt_d = cube_end_s ? {SURF_W{1'b0}} : (s_cnt_q + SURF_W'(1'b1));
      end else begin
        s_cnt_d = s_cnt_q;
      end
    end else begin
      c_cnt_d = c_cnt_q;
      w_cnt_d = w_cnt_q;
      h_cnt_d = h_cnt_q;
      s_cnt_d = s_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      c_cnt_q <= {CPOS_W{1'b0}};
      w_cnt_q <= {CUBE_W{1'b0}};
      h_cnt_q <= {CUBE_W{1'b0}};
      s_cnt_q <= {SURF_W{1'b0}};
    end else begin
      c_cnt_q <= c_cnt_d;
      w_cnt_q <= w_cnt_d;
      h_cnt_q <= h_cnt_d;
      s_cnt_q <= s_cnt_d;
    end
  end

  assign info_o     = pdp_make_info(c_cnt_q, atom_end_s, line_end_s, surf_end_s, cube_end_s);
  assign cube_end_o = cube_end_s;

endmodule

// File: rtl/pdp_core_preproc.sv
// pdp_core_preproc
//   Merges the off-fly (RDMA, already tagged) and on-fly (SDP, raw) PDP input
//   sources into one registered valid/ready stream {info, data} for cal1d.
//   On-fly elements get their info tag from pdp_onfly_pos_cnt.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   reg2dp_op_en        : layer enable; rising edge starts a layer
//   reg2dp_flying_mode  : 0 on-fly (SDP), 1 off-fly (RDMA)
//   reg2dp_cube_in_*    : cube width/height/channel minus one
//   sdp2pdp_*           : on-fly element stream (valid/pd/ready)
//   nan_preproc_*       : off-fly tagged beat stream (pvld/pd/prdy)
//   pre2cal1d_*         : merged output stream (pvld/pd/prdy)
//   onfly_layer_done    : one-cycle pulse after the on-fly cube_end beat
module pdp_core_preproc
  import pdp_preproc_pkg::*;
(
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              reg2dp_op_en,
  input  logic              reg2dp_flying_mode,
  input  logic [12:0]       reg2dp_cube_in_width,
  input  logic [12:0]       reg2dp_cube_in_height,
  input  logic [12:0]       reg2dp_cube_in_channel,
  input  logic              sdp2pdp_valid,
  input  logic [DATA_W-1:0] sdp2pdp_pd,
  output logic              sdp2pdp_ready,
  input  logic              nan_preproc_pvld,
  input  logic [PD_W-1:0]   nan_preproc_pd,
  output logic              nan_preproc_prdy,
  output logic              pre2cal1d_pvld,
  output logic [PD_W-1:0]   pre2cal1d_pd,
  input  logic              pre2cal1d_prdy,
  output logic              onfly_layer_done
);

  logic    op_en_d1_q;
  logic    mode_q, mode_d;
  logic    active_q, active_d;
  logic    out_vld_q, out_vld_d;
  pdp_pd_t out_pd_q, out_pd_d;
  logic    done_q;

  logic              op_en_load_s, take_s, cap_nan_s, cap_sdp_s;
  logic              cube_end_s, cube_acc_s, cnt_clear_s;
  logic [INFO_W-1:0] info_s;
  // Channel bits inside an atom never affect tagging: partial atoms are padded.
  logic              unused_chn_lsb_s;

  assign unused_chn_lsb_s = ^reg2dp_cube_in_channel[CPOS_W-1:0];

  assign op_en_load_s = reg2dp_op_en & ~op_en_d1_q;
  assign take_s       = ~out_vld_q | pre2cal1d_prdy;

  assign nan_preproc_prdy = mode_q & take_s;
  assign sdp2pdp_ready    = ~mode_q & active_q & take_s;

  assign cap_nan_s   = nan_preproc_pvld & nan_preproc_prdy;
  assign cap_sdp_s   = sdp2pdp_valid & sdp2pdp_ready;
  assign cube_acc_s  = cap_sdp_s & cube_end_s;
  assign cnt_clear_s = op_en_load_s | cube_acc_s;

  pdp_onfly_pos_cnt u_pos_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .step_i          (cap_sdp_s),
    .clear_i         (cnt_clear_s),
    .width_i         (reg2dp_cube_in_width),
    .height_i        (reg2dp_cube_in_height),
    .surf_max_i      (reg2dp_cube_in_channel[CUBE_W-1:CPOS_W]),
    .info_o          (info_s),
    .cube_end_o      (cube_end_s)
  );

  // Layer control: a new op_en edge overrides the end-of-cube shutdown.
  always_comb begin
    mode_d   = mode_q;
    active_d = active_q;
    if (op_en_load_s) begin
      mode_d   = reg2dp_flying_mode;
      active_d = ~reg2dp_flying_mode;
    end else if (cube_acc_s) begin
      mode_d   = mode_q;
      active_d = 1'b0;
    end else begin
      mode_d   = mode_q;
      active_d = active_q;
    end
  end

  // Output register next-state: capture the selected source, else drain.
  always_comb begin
    out_vld_d = out_vld_q;
    out_pd_d  = out_pd_q;
    if (cap_nan_s) begin
      out_vld_d = 1'b1;
      out_pd_d  = pdp_pd_t'(nan_preproc_pd);
    end else if (cap_sdp_s) begin
      out_vld_d     = 1'b1;
      out_pd_d.info = info_s;
      out_pd_d.data = sdp2pdp_pd;
    end else if (pre2cal1d_prdy) begin
      out_vld_d = 1'b0;
      out_pd_d  = out_pd_q;
    end else begin
      out_vld_d = out_vld_q;
      out_pd_d  = out_pd_q;
    end
  end

  // State and output registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d1_q <= 1'b0;
      mode_q     <= 1'b1;
      active_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_pd_q   <= {PD_W{1'b0}};
      done_q     <= 1'b0;
    end else begin
      op_en_d1_q <= reg2dp_op_en;
      mode_q     <= mode_d;
      active_q   <= active_d;
      out_vld_q  <= out_vld_d;
      out_pd_q   <= out_pd_d;
      done_q     <= cube_acc_s;
    end
  end

  assign pre2cal1d_pvld   = out_vld_q;
  assign pre2cal1d_pd     = out_pd_q;
  assign onfly_layer_done = done_q;

endmodule
